// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// default opcode/reset constants and instruction field widths.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam int PC_W      = 5;
  localparam int INSTR_W   = 32;
  localparam int OPCODE_W  = 6;
  localparam int REG_W     = 5;
  localparam int IMM_W     = 16;
  localparam int JTARGET_W = 26;

  localparam logic [OPCODE_W-1:0] OP_JUMP_DEF  = 6'd21;
  localparam logic [PC_W-1:0]     RESET_PC_DEF = 5'd2;

endpackage

// File: rtl/fetch_npc.sv
// Next-PC priority select: redirect, then stall hold, then predecoded
// jump, then sequential increment. Purely combinational.
module fetch_npc
  import instr_fetch_pkg::*;
#(
  parameter logic [OPCODE_W-1:0] OP_JUMP = OP_JUMP_DEF
) (
  input  logic [PC_W-1:0]     pc,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  input  logic                stall,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [PC_W-1:0]     jump_target,
  output logic [PC_W-1:0]     npc
);

  always_comb begin
    if (redirect_valid)        npc = redirect_pc;
    else if (stall)            npc = pc;
    else if (opcode == OP_JUMP) npc = jump_target;
    else                       npc = pc + 5'd1;  // 31 wraps to 0
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IF/ID register, IDLE/RUN/HALT
// control and a saturating issue counter.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]     RESET_PC = RESET_PC_DEF,
  parameter logic [OPCODE_W-1:0] OP_JUMP  = OP_JUMP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic [PC_W-1:0]     imem_addr,
  output logic                imem_we,
  output logic                imem_mode,
  input  logic [INSTR_W-1:0]  imem_data,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [PC_W-1:0]     if_pc,
  output logic                if_valid,
  output logic                halted,
  output logic [15:0]         fetch_count
);

  fetch_state_t    state, state_next;
  logic [PC_W-1:0] pc, npc;
  logic            halt_det, issue, pc_load, hold_if;

  assign imem_addr = pc;
  assign imem_we   = 1'b0;
  assign imem_mode = 1'b0;
  assign halted    = (state == ST_HALT);

  fetch_npc #(.OP_JUMP(OP_JUMP)) u_npc (
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .opcode         (imem_data[INSTR_W-1 -: OPCODE_W]),
    .jump_target    (imem_data[PC_W-1:0]),
    .npc            (npc)
  );

  // Redirect and stall both outrank halt detection.
  assign halt_det = (state == ST_RUN) && !redirect_valid && !stall &&
                    (imem_data == '0) && (pc >= RESET_PC);
  assign issue    = (state == ST_RUN) && !redirect_valid && !stall && !halt_det;
  assign pc_load  = ((state == ST_RUN) && !halt_det) ||
                    ((state == ST_HALT) && redirect_valid);
  assign hold_if  = (state == ST_RUN) && stall && !redirect_valid;

  // NOTE: next-state is assigned a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start)          state_next = ST_RUN;
      ST_RUN:  if (halt_det)       state_next = ST_HALT;
      ST_HALT: if (redirect_valid) state_next = ST_RUN;
               else if (start)     state_next = ST_IDLE;
      default:                     state_next = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      if_instr    <= '0;
      if_pc       <= '0;
      if_valid    <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_next;
      if (pc_load) pc <= npc;
      if (issue) begin
        if_instr <= imem_data;
        if_pc    <= pc;
        if_valid <= 1'b1;
        if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      end else if (!hold_if) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a combinational 32-word memory model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [4:0]  redirect_pc = '0;
  logic [4:0]  imem_addr;
  logic        imem_we, imem_mode;
  logic [31:0] imem_data;
  logic [31:0] if_instr;
  logic [4:0]  if_pc;
  logic        if_valid, halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [32];
  int n_cmp = 0;
  int n_err = 0;

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_we(imem_we), .imem_mode(imem_mode),
    .imem_data(imem_data), .if_instr(if_instr), .if_pc(if_pc),
    .if_valid(if_valid), .halted(halted), .fetch_count(fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", if_valid); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got %0b want 0", halted); end
    n_cmp++; if (imem_addr !== 5'd2) begin n_err++; $display("FAIL rst_pc got %0d want 2", imem_addr); end
    n_cmp++; if (fetch_count !== 16'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", fetch_count); end
    n_cmp++; if (if_pc !== 5'd0 || if_instr !== 32'd0) begin n_err++; $display("FAIL rst_ifid got pc=%0d instr=%h want 0/0", if_pc, if_instr); end
    n_cmp++; if (imem_we !== 1'b0 || imem_mode !== 1'b0) begin n_err++; $display("FAIL imem_ctrl got we=%0b mode=%0b want 0/0", imem_we, imem_mode); end
    tick(); tick();
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 5'd2) begin n_err++; $display("FAIL idle_hold got valid=%0b pc=%0d want 0/2", if_valid, imem_addr); end
  endtask

  task automatic test_straight_line();
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 5'd2) begin n_err++; $display("FAIL start_cycle got valid=%0b pc=%0d want 0/2", if_valid, imem_addr); end
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);  // start while running must be ignored
      tick();
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 5'(2 + k) || if_instr !== mem[2 + k]) begin
        n_err++; $display("FAIL straight_%0d got valid=%0b pc=%0d instr=%h want 1/%0d/%h", k, if_valid, if_pc, if_instr, 2 + k, mem[2 + k]);
      end
    end
    start = 1'b0; stall = 1'b1;
    n_cmp++; if (fetch_count !== 16'd5) begin n_err++; $display("FAIL straight_count got %0d want 5", fetch_count); end
  endtask

  task automatic test_jump();
    redirect_valid = 1'b1; redirect_pc = 5'd20; tick();
    redirect_valid = 1'b0; stall = 1'b0;
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 5'd20) begin n_err++; $display("FAIL jump_setup got valid=%0b pc=%0d want 0/20", if_valid, imem_addr); end
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 5'd20 || if_instr !== 32'h5400_000A) begin n_err++; $display("FAIL jump_issue got valid=%0b pc=%0d instr=%h want 1/20/5400000a", if_valid, if_pc, if_instr); end
    n_cmp++; if (imem_addr !== 5'd10) begin n_err++; $display("FAIL jump_target got %0d want 10", imem_addr); end
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 5'd10) begin n_err++; $display("FAIL jump_no_bubble got valid=%0b pc=%0d want 1/10", if_valid, if_pc); end
    n_cmp++; if (fetch_count !== 16'd7) begin n_err++; $display("FAIL jump_count got %0d want 7", fetch_count); end
    tick(); stall = 1'b1;  // issues pc 11, pc now 12
  endtask

  task automatic test_stall_redirect();
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 5'd11 || imem_addr !== 5'd12 || fetch_count !== 16'd8) begin
      n_err++; $display("FAIL stall_hold got valid=%0b ifpc=%0d pc=%0d cnt=%0d want 1/11/12/8", if_valid, if_pc, imem_addr, fetch_count);
    end
    redirect_valid = 1'b1; redirect_pc = 5'd23; tick();
    redirect_valid = 1'b0;
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 5'd23 || fetch_count !== 16'd8) begin
      n_err++; $display("FAIL stall_redirect got valid=%0b pc=%0d cnt=%0d want 0/23/8", if_valid, imem_addr, fetch_count);
    end
  endtask

  task automatic test_halt();
    stall = 1'b0; tick();
    n_cmp++; if (halted !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 5'd23 || fetch_count !== 16'd8) begin
      n_err++; $display("FAIL halt_enter got halted=%0b valid=%0b pc=%0d cnt=%0d want 1/0/23/8", halted, if_valid, imem_addr, fetch_count);
    end
    tick();
    n_cmp++; if (halted !== 1'b1 || imem_addr !== 5'd23 || if_valid !== 1'b0) begin n_err++; $display("FAIL halt_stay got halted=%0b pc=%0d valid=%0b want 1/23/0", halted, imem_addr, if_valid); end
    redirect_valid = 1'b1; redirect_pc = 5'd7; tick(); redirect_valid = 1'b0;
    n_cmp++; if (halted !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 5'd7) begin n_err++; $display("FAIL halt_exit got halted=%0b valid=%0b pc=%0d want 0/0/7", halted, if_valid, imem_addr); end
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 5'd7 || fetch_count !== 16'd9) begin n_err++; $display("FAIL halt_resume got valid=%0b pc=%0d cnt=%0d want 1/7/9", if_valid, if_pc, fetch_count); end
    stall = 1'b1;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 5'd31; tick();
    redirect_valid = 1'b0; stall = 1'b0;
    tick();
    n_cmp++; if (if_pc !== 5'd31 || imem_addr !== 5'd0) begin n_err++; $display("FAIL wrap_31 got ifpc=%0d pc=%0d want 31/0", if_pc, imem_addr); end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 5'(k) || if_instr !== 32'd0 || halted !== 1'b0) begin
        n_err++; $display("FAIL wrap_nop_%0d got valid=%0b pc=%0d instr=%h halted=%0b want 1/%0d/0/0", k, if_valid, if_pc, if_instr, halted, k);
      end
    end
    tick();
    n_cmp++; if (if_pc !== 5'd2 || fetch_count !== 16'd13) begin n_err++; $display("FAIL wrap_after got pc=%0d cnt=%0d want 2/13", if_pc, fetch_count); end
    stall = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1; start = 1'b1; redirect_valid = 1'b1; redirect_pc = 5'd9; tick();
    rst = 1'b0; start = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
    n_cmp++; if (halted !== 1'b0 || imem_addr !== 5'd2 || if_valid !== 1'b0 || fetch_count !== 16'd0 || if_pc !== 5'd0) begin
      n_err++; $display("FAIL rst_mid got halted=%0b pc=%0d valid=%0b cnt=%0d ifpc=%0d want 0/2/0/0/0", halted, imem_addr, if_valid, fetch_count, if_pc);
    end
    tick(); tick(); tick();
    n_cmp++; if (imem_addr !== 5'd2 || if_valid !== 1'b0 || fetch_count !== 16'd0) begin n_err++; $display("FAIL rst_idle got pc=%0d valid=%0b cnt=%0d want 2/0/0", imem_addr, if_valid, fetch_count); end
    start = 1'b1; tick(); start = 1'b0; tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 5'd2 || fetch_count !== 16'd1) begin n_err++; $display("FAIL rst_restart got valid=%0b pc=%0d cnt=%0d want 1/2/1", if_valid, if_pc, fetch_count); end
    stall = 1'b1;
  endtask

  task automatic test_halt_to_idle();
    redirect_valid = 1'b1; redirect_pc = 5'd23; tick();
    redirect_valid = 1'b0; stall = 1'b0; tick();
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL idle_halt got halted=%0b want 1", halted); end
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if (halted !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 5'd23) begin n_err++; $display("FAIL halt_to_idle got halted=%0b valid=%0b pc=%0d want 0/0/23", halted, if_valid, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 5'd5; tick(); redirect_valid = 1'b0; tick();
    n_cmp++; if (imem_addr !== 5'd23 || if_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'd1) begin
      n_err++; $display("FAIL idle_redirect got pc=%0d valid=%0b halted=%0b cnt=%0d want 23/0/0/1", imem_addr, if_valid, halted, fetch_count);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0400_0000 | 32'(i);
    mem[0]  = 32'd0;
    mem[1]  = 32'd0;
    mem[20] = {6'd21, 26'd10};
    mem[23] = 32'd0;
    test_reset();
    test_straight_line();
    test_jump();
    test_stall_redirect();
    test_halt();
    test_wrap();
    test_reset_mid_run();
    test_halt_to_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
